// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and a
// width helper used for the grant index and burst counter.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority picker: returns the first asserted request found searching
// upward from i_ptr+1, wrapping modulo NUM_REQ.
module fifo_write_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    int w_cand;

    // Walk the candidates from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_any  = |i_req;
        o_idx  = '0;
        w_cand = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_cand]) begin
                o_idx = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// locking the grant for one packet or at most MAX_BURST words.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_W    = 8,
    parameter int  MAX_BURST = 4,
    localparam int IDX_W     = clog2(NUM_REQ),
    localparam int CNT_W     = clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_fifo_full,
    output logic                      o_fifo_we,
    output logic [DATA_W-1:0]         o_fifo_din,
    output logic                      o_grant_active,
    output logic [IDX_W-1:0]          o_grant_id,
    output logic                      o_dbg_state,
    output logic [CNT_W-1:0]          o_dbg_burst_cnt
);

    // Handshake: a word moves from producer to FIFO in any cycle where the
    // producer's valid and its ready are both high; ready is only ever offered
    // to the grantee and only while the FIFO is not full.

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant_id;
    logic [CNT_W-1:0]   r_burst_cnt;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_granted;
    logic               w_xfer;
    logic               w_release;

    fifo_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req (i_req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    assign w_granted = (r_state == ST_GRANT);
    assign w_xfer    = w_granted && i_req_valid[r_grant_id] && !i_fifo_full;
    assign w_release = w_xfer &&
                       (i_req_last[r_grant_id] || (r_burst_cnt == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        o_req_ready = '0;
        if (w_granted && !i_fifo_full) begin
            o_req_ready[r_grant_id] = 1'b1;
        end
        o_fifo_din = '0;
        if (w_granted) begin
            o_fifo_din = i_req_data[r_grant_id*DATA_W +: DATA_W];
        end
    end

    assign o_fifo_we       = w_xfer;
    assign o_grant_active  = w_granted;
    assign o_grant_id      = r_grant_id;
    assign o_dbg_state     = r_state;
    assign o_dbg_burst_cnt = r_burst_cnt;

    // The IDLE cycle is the arbitration slot; no word moves in it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant_id  <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_rr_ptr    <= r_grant_id;
                        r_burst_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: vector table, directed corner sequences and
// random traffic against a packet-level reference model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_we;
  logic [DW-1:0] fifo_din;
  logic          grant_active;
  logic [1:0]    grant_id;
  logic          dbg_state;
  logic [2:0]    dbg_cnt;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_last      (req_last),
    .o_req_ready     (req_ready),
    .i_fifo_full     (fifo_full),
    .o_fifo_we       (fifo_we),
    .o_fifo_din      (fifo_din),
    .o_grant_active  (grant_active),
    .o_grant_id      (grant_id),
    .o_dbg_state     (dbg_state),
    .o_dbg_burst_cnt (dbg_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, how many words it has moved, who
  // was served last.
  int m_owner;
  int m_words;
  int m_prev;
  int m_last_id;
  logic          e_we;
  logic [DW-1:0] e_din;
  logic [N-1:0]  e_ready;
  logic          e_active;
  logic [1:0]    e_gid;

  logic [DW-1:0] exp_q[$];
  int            wr_ids[$];

  logic          s_we;
  logic [DW-1:0] s_din;
  logic [N-1:0]  s_ready;
  logic          s_active;
  logic [1:0]    s_gid;
  logic [2:0]    s_cnt;

  task automatic model_reset();
    m_owner   = -1;
    m_words   = 0;
    m_prev    = N - 1;
    m_last_id = 0;
  endtask

  task automatic model_outputs();
    e_active = (m_owner >= 0);
    e_gid    = 2'(m_last_id);
    e_ready  = '0;
    e_we     = 1'b0;
    e_din    = '0;
    if (m_owner >= 0) begin
      e_din = req_data[m_owner*DW +: DW];
      if (!fifo_full) begin
        e_ready[m_owner] = 1'b1;
        e_we = req_valid[m_owner];
      end
    end
  endtask

  task automatic model_next();
    if (m_owner < 0) begin
      if (req_valid != '0) begin
        for (int k = N; k >= 1; k--) begin
          if (req_valid[(m_prev + k) % N]) m_owner = (m_prev + k) % N;
        end
        m_last_id = m_owner;
        m_words = 0;
      end
    end else if (e_we) begin
      m_words++;
      if (req_last[m_owner] || m_words == MB) begin
        m_prev  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 time
  // unit after the rising edge so the caller can drive the next inputs.
  task automatic step();
    @(negedge clk);
    model_outputs();
    s_we = fifo_we; s_din = fifo_din; s_ready = req_ready;
    s_active = grant_active; s_gid = grant_id; s_cnt = dbg_cnt;
    chk("fifo_we", 32'(s_we), 32'(e_we));
    chk("fifo_din", 32'(s_din), 32'(e_din));
    chk("req_ready", 32'(s_ready), 32'(e_ready));
    chk("grant_active", 32'(s_active), 32'(e_active));
    chk("grant_id", 32'(s_gid), 32'(e_gid));
    if (e_we) exp_q.push_back(e_din);
    if (s_we) begin
      wr_ids.push_back(int'(s_gid));
      if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(s_din), 32'hFFFF_FFFF);
      else chk("sb_din", 32'(s_din), 32'(exp_q.pop_front()));
    end
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic f, input logic [N*DW-1:0] d);
    req_valid = v; req_last = l; fifo_full = f; req_data = d;
  endtask

  task automatic sync_reset();
    drive('0, '0, 1'b0, '0);
    rst = 1'b1;
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    wr_ids.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]    valid;
    logic [N-1:0]    last;
    logic            full;
    logic [N*DW-1:0] data;
    logic            we;
    logic [DW-1:0]   din;
    logic [N-1:0]    ready;
    logic            active;
    logic [1:0]      gid;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                              input logic [31:0] d, input logic we, input logic [7:0] din,
                              input logic [3:0] rdy, input logic act, input logic [1:0] gid);
    vec_t r;
    r.valid = v; r.last = l; r.full = f; r.data = d;
    r.we = we; r.din = din; r.ready = rdy; r.active = act; r.gid = gid;
    return r;
  endfunction

  initial begin
    // Requester 0 sends A1..A3, then requester 1 sends B1,B2 with a full stall.
    vecs[0] = mk(4'b0001, 4'b0000, 1'b0, 32'h000000A1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    vecs[1] = mk(4'b0001, 4'b0000, 1'b0, 32'h000000A1, 1'b1, 8'hA1, 4'b0001, 1'b1, 2'd0);
    vecs[2] = mk(4'b0001, 4'b0000, 1'b0, 32'h3C3C3CA2, 1'b1, 8'hA2, 4'b0001, 1'b1, 2'd0);
    vecs[3] = mk(4'b0001, 4'b0001, 1'b0, 32'h000000A3, 1'b1, 8'hA3, 4'b0001, 1'b1, 2'd0);
    vecs[4] = mk(4'b0000, 4'b0000, 1'b0, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    vecs[5] = mk(4'b0010, 4'b0000, 1'b0, 32'h0000B100, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
    vecs[6] = mk(4'b0010, 4'b0000, 1'b0, 32'h5A5AB15A, 1'b1, 8'hB1, 4'b0010, 1'b1, 2'd1);
    vecs[7] = mk(4'b0010, 4'b0000, 1'b1, 32'h0000B200, 1'b0, 8'hB2, 4'b0000, 1'b1, 2'd1);
    vecs[8] = mk(4'b0010, 4'b0010, 1'b0, 32'h0000B200, 1'b1, 8'hB2, 4'b0010, 1'b1, 2'd1);
    vecs[9] = mk(4'b0000, 4'b0000, 1'b0, 32'h00000000, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd1);

    model_reset();
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(fifo_we), 32'd0);
    chk("rst_din", 32'(fifo_din), 32'd0);
    chk("rst_active", 32'(grant_active), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_cnt", 32'(dbg_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].data);
      step();
      chk($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_din", i), 32'(s_din), 32'(vecs[i].din));
      chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d_active", i), 32'(s_active), 32'(vecs[i].active));
      chk($sformatf("vec%0d_gid", i), 32'(s_gid), 32'(vecs[i].gid));
    end

    // All four requesters streaming without req_last: bursts of MB, order 0..3,0.
    sync_reset();
    drive(4'b1111, 4'b0000, 1'b0, 32'h44332211);
    for (int i = 0; i < 22; i++) step();
    chk("rr_write_count", 32'(wr_ids.size()), 32'd17);
    for (int i = 0; i < 17 && i < wr_ids.size(); i++)
      chk($sformatf("rr_write%0d_id", i), 32'(wr_ids[i]), 32'((i / 4) % 4));

    // FIFO full for 3 cycles after requester 1's second word.
    sync_reset();
    drive(4'b0010, 4'b0000, 1'b0, 32'h00001100);
    step(); step();
    req_data = 32'h00001200;
    step();
    for (int i = 0; i < 3; i++) begin
      req_data = 32'h00001300;
      fifo_full = 1'b1;
      step();
      chk("full_we", 32'(s_we), 32'd0);
      chk("full_ready", 32'(s_ready), 32'd0);
      chk("full_cnt", 32'(s_cnt), 32'd2);
    end
    fifo_full = 1'b0;
    step();
    chk("full_resume_w3", 32'(s_din), 32'h13);
    req_data = 32'h00001400;
    step();
    chk("full_w4_we", 32'(s_we), 32'd1);
    chk("full_w4_cnt", 32'(s_cnt), 32'd3);
    step();
    chk("full_released", 32'(s_active), 32'd0);

    // Requester 2 pauses mid-packet while requester 0 waits.
    sync_reset();
    drive(4'b0100, 4'b0000, 1'b0, 32'h00C10000);
    step(); step();
    drive(4'b0001, 4'b0000, 1'b0, 32'h00C200E0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("gap_gid", 32'(s_gid), 32'd2);
      chk("gap_we", 32'(s_we), 32'd0);
      chk("gap_ready", 32'(s_ready), 32'b0100);
    end
    drive(4'b0101, 4'b0100, 1'b0, 32'h00C200E0);
    step();
    chk("gap_last_din", 32'(s_din), 32'hC2);
    drive(4'b0001, 4'b0000, 1'b0, 32'h000000E0);
    step();
    chk("gap_bubble", 32'(s_active), 32'd0);
    step();
    chk("gap_next_gid", 32'(s_gid), 32'd0);
    chk("gap_next_din", 32'(s_din), 32'hE0);

    // Asynchronous reset during requester 2's second word.
    sync_reset();
    drive(4'b0100, 4'b0000, 1'b0, 32'h00D10000);
    step(); step();
    req_data = 32'h00D20000;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_we", 32'(fifo_we), 32'd0);
    chk("arst_din", 32'(fifo_din), 32'd0);
    chk("arst_active", 32'(grant_active), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    chk("arst_cnt", 32'(dbg_cnt), 32'd0);
    exp_q.delete();
    wr_ids.delete();
    model_reset();
    @(posedge clk);
    #1;
    drive(4'b1001, 4'b1001, 1'b0, 32'hF3000000 | 32'h000000F0);
    rst = 1'b0;
    step(); step();
    chk("arst_first_gid", 32'(s_gid), 32'd0);
    chk("arst_first_din", 32'(s_din), 32'hF0);

    // Single-word packets from 0 and 3 alternate with one idle cycle between.
    sync_reset();
    drive(4'b1001, 4'b1001, 1'b0, 32'hD30000D0);
    for (int i = 0; i < 8; i++) step();
    chk("alt_count", 32'(wr_ids.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_ids.size(); i++)
      chk($sformatf("alt%0d_id", i), 32'(wr_ids[i]), (i % 2 == 0) ? 32'd0 : 32'd3);

    // Random traffic checked every cycle against the model.
    sync_reset();
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0), $urandom);
      step();
    end
    drive('0, '0, 1'b0, '0);
    for (int i = 0; i < 2; i++) step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one FIFO write port between NUM_REQ independent producers, using round-robin arbitration with burst locking.
- Sits directly in front of the FIFO write side: drives the FIFO's we/din and is throttled by the FIFO's fifo_full flag.
- Each producer uses a valid/ready handshake. A grant is held for one packet, ending at req_last, or for at most MAX_BURST words.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, data word width in bits.
- MAX_BURST, 4, maximum words transferred per grant; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  per-requester last-word-of-packet marker; qualified by valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- fifo_full  input  1  FIFO full flag.
- fifo_we  output  1  FIFO write enable.
- fifo_din  output  DATA_W  FIFO write data.
- grant_active  output  1  high while a requester holds the grant.
- grant_id  output  clog2(NUM_REQ)  index of the current or most recent grantee.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has top priority after reset.
  - burst_cnt=0, grant_id=0, grant_active=0.
  - req_ready=0, fifo_we=0, fifo_din=0.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid bit is high, select the first asserted index searching upward from rr_ptr+1, modulo NUM_REQ.
  - Register that index into grant_id, clear burst_cnt, go to GRANT.
  - No transfer occurs in IDLE, giving exactly one cycle of arbitration latency.
  - If no req_valid bit is high, stay in IDLE.
- GRANT, all combinational on registered grant_id:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - fifo_we = req_valid[grant_id] && !fifo_full.
  - fifo_din = grant slice of req_data while grant_active, else 0.
  - A transfer is a cycle with fifo_we=1; burst_cnt increments by 1 on each transfer.
- Release: on a transfer cycle where req_last[grant_id]=1 or burst_cnt==MAX_BURST-1:
  - rr_ptr<=grant_id, state<=IDLE.
  - grant_id keeps its value; grant_active drops in the next cycle.
- Gaps: in GRANT with req_valid[grant_id]=0, hold the grant and count nothing. Producers must complete packets; there is no timeout.
- fifo_full=1 in GRANT: req_ready=0, fifo_we=0, burst_cnt and state unchanged. Transfers resume the cycle fifo_full drops.
- Requester identity:
  - Non-granted requesters that keep req_valid high are never written; their data is ignored.
  - Arbitration looks only at req_valid, never at req_last.
- Back-to-back grants: every release is followed by one IDLE bubble cycle, so fairness is bounded. With all requesters active, each is granted once per NUM_REQ grants.
- rr_ptr wraps from NUM_REQ-1 to 0. burst_cnt width is clog2(MAX_BURST+1) and never exceeds MAX_BURST-1.
- Reset mid-burst: everything returns to reset values immediately and asynchronously. The partial packet is abandoned; cleanup is the FIFO owner's responsibility.
- Guarantee: at most one FIFO write per cycle, and never a write while fifo_full=1.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - clog2 function for grant_id and burst_cnt widths.
- One sub-module, rr_pick:
  - purely combinational.
  - inputs: req vector, pointer.
  - outputs: any_req, selected index, rotating priority search.
  - instantiated once; lets the priority logic be unit-tested separately.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-word packet 0xA1,0xA2,0xA3 (last on word 3):
  - IDLE 1 cycle, then fifo_we high for 3 cycles with din A1,A2,A3.
  - grant_active falls the cycle after A3.
- All four requesters valid continuously, no req_last, MAX_BURST=4:
  - grant order 0,1,2,3,0.
  - exactly 4 writes per grant, one bubble between grants.
- fifo_full asserted for 3 cycles mid-burst after word 2 of requester 1:
  - req_ready=0 and fifo_we=0 throughout.
  - burst_cnt holds at 2; words 3 and 4 are written after full drops.
  - release occurs after the 4th word.
- Requester 2 drops req_valid for 2 cycles mid-packet while requester 0 is valid:
  - the grant stays on 2 and requester 0 is not written.
  - after 2's req_last, requester 0 (next after ptr=2, wrapping) is granted.
- Assert rst during the 2nd word of a burst:
  - all outputs reach reset values asynchronously.
  - after release, requester 0 wins first even if requester 3 is also valid.
- req_last on the first word with MAX_BURST=1 and requesters 0 and 3 active:
  - single-word grants alternate 0,3,0,3, each separated by one IDLE cycle.
